// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the mem_responder data memory: bus widths,
// the array base address and the drain FSM state encoding.
package mem_responder_pkg;

  localparam int          MEM_BUS_W  = 64;
  localparam int          MEM_ADDR_W = 64;
  localparam logic [63:0] MEM_BASE   = 64'h8000_0000;

  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } drain_state_e;

endpackage

// File: rtl/mem_responder_store_buf.sv
// Circular store buffer for mem_responder: {index,data} FIFO with push/pop and
// a combinational youngest-entry match search used for load forwarding.
module mem_responder_store_buf #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 12,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [IDX_W-1:0]           push_idx_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic [IDX_W-1:0]           look_idx_i,
  output logic                       hit_o,
  output logic [DATA_W-1:0]          hit_data_o,
  output logic [IDX_W-1:0]           head_idx_o,
  output logic [DATA_W-1:0]          head_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  slot;

  // NOTE: entry storage is deliberately not reset; count_q alone decides which
  // slots are valid, so clearing the payload would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_i) begin
      idx_q[tail_q]  <= push_idx_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  always_comb begin
    head_d  = pop_i  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
    if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match wins.
  // NOTE: every output gets a default before the loop, otherwise a path that
  // never matches would infer a latch.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    slot       = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (idx_q[slot] == look_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[slot];
      end
    end
  end

  assign head_idx_o  = idx_q[head_q];
  assign head_data_o = data_q[head_q];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;

endmodule

// File: rtl/mem_responder.sv
// Data memory answering the core's load/store port: posted store buffer that
// drains into a word array with WR_LAT-cycle writes. Define MEM_RESP_FWD_EN to
// forward loads from the store buffer; otherwise matching loads stall.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                DATA_W   = MEM_BUS_W,
  parameter int                ADDR_W   = MEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(MEM_BASE),
  parameter int                IDX_W    = 12,
  parameter int                SB_DEPTH = 4,
  parameter int                WR_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_raddr_i,
  input  logic [ADDR_W-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              hold_o,
  output logic              sb_empty_o
);

  localparam int                CNT_W = $clog2(SB_DEPTH) + 1;
  localparam int                LAT_W = $clog2(WR_LAT + 1);
  localparam logic [ADDR_W-1:0] LIMIT = BASE + (ADDR_W'(1) << (IDX_W + 3));

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE) >> 3);
  endfunction

  logic [DATA_W-1:0] arr_q [2**IDX_W];

  drain_state_e      state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              r_in, w_in;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic              store_req, push_w, retire_w;
  logic              hit_w, full_w, empty_w;
  logic [DATA_W-1:0] hit_data_w, head_data_w;
  logic [IDX_W-1:0]  head_idx_w;
  logic [CNT_W-1:0]  count_w;

  assign r_in  = (mem_raddr_i >= BASE) && (mem_raddr_i < LIMIT);
  assign w_in  = (mem_waddr_i >= BASE) && (mem_waddr_i < LIMIT);
  assign r_idx = word_idx(mem_raddr_i);
  assign w_idx = word_idx(mem_waddr_i);

  // A full buffer still accepts a store in the cycle its head retires.
  assign retire_w  = (state_q == SB_BUSY) && (lat_q == '0);
  assign store_req = !rst && mem_ce_i && mem_we_i && w_in;
  assign push_w    = store_req && (!full_w || retire_w);

  mem_responder_store_buf #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (SB_DEPTH)
  ) u_store_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_w),
    .push_idx_i  (w_idx),
    .push_data_i (mem_wdata_i),
    .pop_i       (retire_w),
    .look_idx_i  (r_idx),
    .hit_o       (hit_w),
    .hit_data_o  (hit_data_w),
    .head_idx_o  (head_idx_w),
    .head_data_o (head_data_w),
    .full_o      (full_w),
    .empty_o     (empty_w),
    .count_o     (count_w)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      SB_IDLE: begin
        if (!empty_w) begin
          state_d = SB_BUSY;
          lat_d   = LAT_W'(WR_LAT - 1);
        end
      end
      SB_BUSY: begin
        if (retire_w) begin
          if ((count_w != CNT_W'(1)) || push_w) lat_d = LAT_W'(WR_LAT - 1);
          else                                  state_d = SB_IDLE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // A reset in the retiring cycle abandons the write.
  always_ff @(posedge clk) begin
    if (retire_w && !rst) arr_q[head_idx_w] <= head_data_w;
  end

  always_comb begin
    mem_rdata_o = '0;
    hold_o      = 1'b0;
    if (!rst && mem_ce_i) begin
      if (mem_we_i) begin
        hold_o = w_in && full_w && !retire_w;
      end else if (r_in) begin
`ifdef MEM_RESP_FWD_EN
        mem_rdata_o = hit_w ? hit_data_w : arr_q[r_idx];
`else
        if (hit_w) hold_o      = 1'b1;
        else       mem_rdata_o = arr_q[r_idx];
`endif
      end
    end
  end

`ifndef MEM_RESP_FWD_EN
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data_w;
`endif

  assign sb_empty_o = empty_w && (state_q == SB_IDLE);

endmodule
